float_align: RTL and testbench

FLOAT_ALIGN -- requirements
Module: float_align

---
 rtl/float_align_pkg.sv | 27 ++
 rtl/float_align_shift_sticky.sv | 29 ++
 rtl/float_align.sv | 149 ++++++++++++++
 tb/tb_float_align.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_align_pkg.sv
// Shared float-format definitions for the alignment stage: width derivations
// and the unpacked operand view. Default format is IEEE-754 single precision.
package float_align_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  function automatic int float_width(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Aligned mantissa: hidden + stored mantissa + guard/round/sticky.
  function automatic int align_width(input int man_w);
    return man_w + 4;
  endfunction

  localparam int FLOAT_W = float_width(EXP_W, MAN_W);
  localparam int AW_W    = align_width(MAN_W);

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic             hidden;
    logic [MAN_W-1:0] man;
  } operand_t;

endpackage

// File: rtl/float_align_shift_sticky.sv
// Right shift of the aligned mantissa; with FLOAT_ALIGN_STICKY_EN defined,
// every bit shifted out is OR-folded into bit 0.
module float_shift_sticky #(
  parameter int AW          = 27,
  parameter int SHIFT_WIDTH = 8
) (
  input  logic [AW-1:0]          data_i,
  input  logic [SHIFT_WIDTH-1:0] shamt_i,
  output logic [AW-1:0]          data_o
);

`ifdef FLOAT_ALIGN_STICKY_EN
  logic [AW-1:0] shifted;
  logic [AW-1:0] lost_mask;
  logic          sticky;

  // Oversized shifts give shifted == 0 and an all-ones mask, so the
  // d >= AW case falls out as {zeros, |data_i} without a special branch.
  always_comb begin
    shifted   = data_i >> shamt_i;
    lost_mask = ~({AW{1'b1}} << shamt_i);
    sticky    = |(data_i & lost_mask);
    data_o    = {shifted[AW-1:1], shifted[0] | sticky};
  end
`else
  assign data_o = data_i >> shamt_i;
`endif

endmodule

// File: rtl/float_align.sv
// Two-stage operand alignment for a float adder: S1 unpacks and forms the
// exponent difference, S2 shifts rhs. Sticky folding is controlled by
// FLOAT_ALIGN_STICKY_EN.
// Handshake: a beat transfers on a rising edge where valid && ready; a
// producer holding valid keeps its data stable until that edge.
module float_align
  import float_align_pkg::*;
#(
  parameter int EXP_WIDTH = EXP_W,
  parameter int MAN_WIDTH = MAN_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [float_width(EXP_WIDTH,MAN_WIDTH)-1:0] lhs,
  input  logic [float_width(EXP_WIDTH,MAN_WIDTH)-1:0] rhs,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic                                     out_sign_l,
  output logic                                     out_sign_r,
  output logic [EXP_WIDTH-1:0]                     out_exp,
  output logic [align_width(MAN_WIDTH)-1:0]        out_man_l,
  output logic [align_width(MAN_WIDTH)-1:0]        out_man_r
);

  localparam int FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH);
  localparam int AW          = align_width(MAN_WIDTH);

  operand_t             op_l, op_r;
  logic [EXP_WIDTH-1:0] eff_l, eff_r;
  logic [EXP_WIDTH:0]   diff;
  logic [EXP_WIDTH-1:0] shamt;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_sign_l_q, s1_sign_l_d, s1_sign_r_q, s1_sign_r_d;
  logic [EXP_WIDTH-1:0] s1_exp_q, s1_exp_d, s1_d_q, s1_d_d;
  logic [AW-1:0]        s1_man_l_q, s1_man_l_d, s1_man_r_q, s1_man_r_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_sign_l_q, out_sign_l_d, out_sign_r_q, out_sign_r_d;
  logic [EXP_WIDTH-1:0] out_exp_q, out_exp_d;
  logic [AW-1:0]        out_man_l_q, out_man_l_d, out_man_r_q, out_man_r_d;
  logic [AW-1:0]        man_r_shifted;

  logic s1_adv, s2_adv;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    op_l = '{sign: lhs[FLOAT_WIDTH-1], exp: lhs[FLOAT_WIDTH-2 -: EXP_WIDTH],
             hidden: |lhs[FLOAT_WIDTH-2 -: EXP_WIDTH], man: lhs[MAN_WIDTH-1:0]};
    op_r = '{sign: rhs[FLOAT_WIDTH-1], exp: rhs[FLOAT_WIDTH-2 -: EXP_WIDTH],
             hidden: |rhs[FLOAT_WIDTH-2 -: EXP_WIDTH], man: rhs[MAN_WIDTH-1:0]};
    // Subnormals share the scale of exponent 1.
    eff_l = op_l.hidden ? op_l.exp : {{(EXP_WIDTH-1){1'b0}}, 1'b1};
    eff_r = op_r.hidden ? op_r.exp : {{(EXP_WIDTH-1){1'b0}}, 1'b1};
    diff  = {1'b0, eff_l} - {1'b0, eff_r};
    shamt = diff[EXP_WIDTH] ? '0 : diff[EXP_WIDTH-1:0];
  end

  float_shift_sticky #(
    .AW          (AW),
    .SHIFT_WIDTH (EXP_WIDTH)
  ) u_shift (
    .data_i  (s1_man_r_q),
    .shamt_i (s1_d_q),
    .data_o  (man_r_shifted)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_l_d  = s1_sign_l_q;
    s1_sign_r_d  = s1_sign_r_q;
    s1_exp_d     = s1_exp_q;
    s1_d_d       = s1_d_q;
    s1_man_l_d   = s1_man_l_q;
    s1_man_r_d   = s1_man_r_q;
    out_valid_d  = out_valid_q;
    out_sign_l_d = out_sign_l_q;
    out_sign_r_d = out_sign_r_q;
    out_exp_d    = out_exp_q;
    out_man_l_d  = out_man_l_q;
    out_man_r_d  = out_man_r_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_l_d = op_l.sign;
        s1_sign_r_d = op_r.sign;
        s1_exp_d    = eff_l;
        s1_d_d      = shamt;
        s1_man_l_d  = {op_l.hidden, op_l.man, 3'b000};
        s1_man_r_d  = {op_r.hidden, op_r.man, 3'b000};
      end
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sign_l_d = s1_sign_l_q;
        out_sign_r_d = s1_sign_r_q;
        out_exp_d    = s1_exp_q;
        out_man_l_d  = s1_man_l_q;
        out_man_r_d  = man_r_shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_l_q  <= 1'b0;
      s1_sign_r_q  <= 1'b0;
      s1_exp_q     <= '0;
      s1_d_q       <= '0;
      s1_man_l_q   <= '0;
      s1_man_r_q   <= '0;
      out_valid_q  <= 1'b0;
      out_sign_l_q <= 1'b0;
      out_sign_r_q <= 1'b0;
      out_exp_q    <= '0;
      out_man_l_q  <= '0;
      out_man_r_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_l_q  <= s1_sign_l_d;
      s1_sign_r_q  <= s1_sign_r_d;
      s1_exp_q     <= s1_exp_d;
      s1_d_q       <= s1_d_d;
      s1_man_l_q   <= s1_man_l_d;
      s1_man_r_q   <= s1_man_r_d;
      out_valid_q  <= out_valid_d;
      out_sign_l_q <= out_sign_l_d;
      out_sign_r_q <= out_sign_r_d;
      out_exp_q    <= out_exp_d;
      out_man_l_q  <= out_man_l_d;
      out_man_r_q  <= out_man_r_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sign_l = out_sign_l_q;
  assign out_sign_r = out_sign_r_q;
  assign out_exp    = out_exp_q;
  assign out_man_l  = out_man_l_q;
  assign out_man_r  = out_man_r_q;

endmodule

// File: tb/tb_float_align.sv
// Bench for float_align: directed alignment cases, stall/back-pressure,
// full-rate flow, randomized traffic against an arithmetic model, reset flush.
module tb_float_align;

  localparam int EW = 8;
  localparam int FW = 32;
  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] lhs = '0;
  logic [FW-1:0] rhs = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sign_l, out_sign_r;
  logic [EW-1:0] out_exp;
  logic [AW-1:0] out_man_l, out_man_r;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  bit rand_done;

  always #5 clk = ~clk;

  float_align dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lhs        (lhs),
    .rhs        (rhs),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign_l (out_sign_l),
    .out_sign_r (out_sign_r),
    .out_exp    (out_exp),
    .out_man_l  (out_man_l),
    .out_man_r  (out_man_r)
  );

  // Output collector: a beat seen at negedge with valid && ready leaves at the next posedge.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      obs_q.push_back({out_sign_l, out_sign_r, out_exp, out_man_l, out_man_r});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: alignment as integer scaling; sticky = nonzero remainder.
  function automatic logic [63:0] model(input logic [31:0] l, input logic [31:0] r);
    int el, er, d;
    longint unsigned ml, mr, sh, lost, scale;
    el = int'(l[30:23]);
    er = int'(r[30:23]);
    ml = ((el != 0) ? 64'd8388608 : 64'd0) + 64'(l[22:0]);
    mr = ((er != 0) ? 64'd8388608 : 64'd0) + 64'(r[22:0]);
    ml = ml * 8;
    mr = mr * 8;
    if (el == 0) el = 1;
    if (er == 0) er = 1;
    d = el - er;
    if (d < 0) d = 0;
    if (d >= 40) begin
      sh   = 0;
      lost = mr;
    end else begin
      scale = 64'd1 << d;
      sh    = mr / scale;
      lost  = mr % scale;
    end
`ifdef FLOAT_ALIGN_STICKY_EN
    if (lost != 0) sh = sh | 64'd1;
`endif
    return {l[31], r[31], el[7:0], ml[26:0], sh[26:0]};
  endfunction

  // Call at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input logic [31:0] l, input logic [31:0] r, output int waits);
    bit ok;
    waits = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    lhs = l;
    rhs = r;
    while (!ok && waits <= 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (ok) begin
      exp_q.push_back(model(l, r));
      @(posedge clk); #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int cyc = 0;
    while (obs_q.size() < n && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    ok = (obs_q.size() >= n);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    lhs = 32'h40400000;
    rhs = 32'h3F800000;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_exp !== '0) begin errors++; $display("FAIL reset_out_exp: got %h expected 0", out_exp); end
    checks++; if (out_man_l !== '0) begin errors++; $display("FAIL reset_out_man_l: got %h expected 0", out_man_l); end
    checks++; if (out_man_r !== '0) begin errors++; $display("FAIL reset_out_man_r: got %h expected 0", out_man_r); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignore_in_valid: out_valid %b expected 0", out_valid); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] tl[6], tr[6];
    logic [7:0]  te[6];
    logic [AW-1:0] tml[6], tmr[6];
    int w;
    tl[0] = 32'h40400000; tr[0] = 32'h3F800000; te[0] = 8'h80; tml[0] = 27'h6000000; tmr[0] = 27'h2000000;
    tl[1] = 32'h4F800000; tr[1] = 32'h3F800001; te[1] = 8'h9F; tml[1] = 27'h4000000;
    tl[2] = 32'h00800000; tr[2] = 32'h00000001; te[2] = 8'h01; tml[2] = 27'h4000000; tmr[2] = 27'h0000008;
    tl[3] = 32'h3F800000; tr[3] = 32'h40000000; te[3] = 8'h7F; tml[3] = 27'h4000000; tmr[3] = 27'h4000000;
    tl[4] = 32'h42000000; tr[4] = 32'h3F800003; te[4] = 8'h84; tml[4] = 27'h4000000;
    tl[5] = 32'hC0400000; tr[5] = 32'hBF800000; te[5] = 8'h80; tml[5] = 27'h6000000; tmr[5] = 27'h2000000;
`ifdef FLOAT_ALIGN_STICKY_EN
    tmr[1] = 27'h0000001;
    tmr[4] = 27'h0200001;
`else
    tmr[1] = 27'h0000000;
    tmr[4] = 27'h0200000;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(tl[i], tr[i], w);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_latency_early: out_valid %b expected 0", i, out_valid); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: out_valid %b expected 1", i, out_valid); end
      checks++; if (out_exp !== te[i]) begin errors++; $display("FAIL dir%0d_exp: got %h expected %h", i, out_exp, te[i]); end
      checks++; if (out_man_l !== tml[i]) begin errors++; $display("FAIL dir%0d_man_l: got %h expected %h", i, out_man_l, tml[i]); end
      checks++; if (out_man_r !== tmr[i]) begin errors++; $display("FAIL dir%0d_man_r: got %h expected %h", i, out_man_r, tmr[i]); end
      checks++; if ({out_sign_l, out_sign_r} !== {tl[i][31], tr[i][31]}) begin
        errors++; $display("FAIL dir%0d_signs: got %b%b expected %b%b", i, out_sign_l, out_sign_r, tl[i][31], tr[i][31]);
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vl[3], vr[3];
    int w;
    bit ok;
    logic [63:0] e, o;
    vl[0] = 32'h40A00000; vr[0] = 32'h40000000;
    vl[1] = 32'h41200000; vr[1] = 32'h3F000001;
    vl[2] = 32'hC1000000; vr[2] = 32'h3E800007;
    out_ready = 1'b0;
    send(vl[0], vr[0], w);
    send(vl[1], vr[1], w);
    checks++; if (w !== 0) begin errors++; $display("FAIL b2b_second_accept: waited %0d expected 0", w); end
    in_valid = 1'b1;
    lhs = vl[2];
    rhs = vr[2];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d: got %b expected 0", c, in_ready); end
      checks++; if ({out_valid, out_sign_l, out_sign_r, out_exp, out_man_l, out_man_r} !== {1'b1, exp_q[0]}) begin
        errors++; $display("FAIL b2b_stall_hold c%0d: got %b_%h expected 1_%h", c, out_valid,
                          {out_sign_l, out_sign_r, out_exp, out_man_l, out_man_r}, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(vl[2], vr[2], w);
    wait_obs(3, ok);
    checks++; if (!ok || obs_q.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d outputs expected 3", obs_q.size()); end
    for (int i = 0; i < 3; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 64'hX;
      checks++; if (o !== e) begin errors++; $display("FAIL b2b_order%0d: got %h expected %h", i, o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_full_rate();
    int w;
    bit ok;
    logic [63:0] e, o;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send($urandom, $urandom & 32'h3FFFFFFF, w);
      if (i > 0) begin
        checks++; if (w !== 0) begin errors++; $display("FAIL full_rate_wait%0d: waited %0d expected 0", i, w); end
      end
    end
    wait_obs(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_rate_count: got %0d outputs expected 10", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL full_rate_data: got %h expected %h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    int n = 300;
    logic [63:0] e, o;
    rand_done = 1'b0;
    fork
      begin
        int w;
        logic [31:0] l, r;
        int el, er;
        for (int i = 0; i < n; i++) begin
          el = $urandom_range(0, 255);
          er = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, el);
          l = {1'($urandom), 8'(el), 23'($urandom)};
          r = {1'($urandom), 8'(er), 23'($urandom)};
          if ($urandom_range(0, 7) == 0) r[22:0] = 23'($urandom_range(0, 3));
          send(l, r, w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_obs(n, ok);
    checks++; if (!ok || obs_q.size() != n) begin errors++; $display("FAIL random_count: got %0d outputs expected %0d", obs_q.size(), n); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL random_data: got %h expected %h", o, e); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_flush();
    int w;
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F800001, w);
    send(32'hC2000000, 32'h41000003, w);
    in_valid = 1'b1;
    lhs = 32'h45000000;
    rhs = 32'h44000001;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_exp !== '0) begin errors++; $display("FAIL flush_out_exp: got %h expected 0", out_exp); end
    checks++; if (out_man_l !== '0) begin errors++; $display("FAIL flush_out_man_l: got %h expected 0", out_man_l); end
    checks++; if (out_man_r !== '0) begin errors++; $display("FAIL flush_out_man_r: got %h expected 0", out_man_r); end
    checks++; if ({out_sign_l, out_sign_r} !== 2'b00) begin errors++; $display("FAIL flush_signs: got %b%b expected 00", out_sign_l, out_sign_r); end
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_output: out_valid %b expected 0", out_valid); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_full_rate();
    test_random();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
